// File: rtl/mem_share_arbiter_pkg.sv
// mem_share_pkg: shared state type, sizes and one-hot owner codes for the memory-share arbiter
package mem_share_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    localparam logic [N_REQ-1:0] GRANT_1 = 4'b0001;
    localparam logic [N_REQ-1:0] GRANT_2 = 4'b0010;
    localparam logic [N_REQ-1:0] GRANT_3 = 4'b0100;
    localparam logic [N_REQ-1:0] GRANT_4 = 4'b1000;

    typedef enum logic [1:0] {IDLE, OWNED, GAP} state_t;

    // Owner index to the busy_1..busy_4 code the distributor mux decodes
    function automatic logic [N_REQ-1:0] idx_to_grant(input logic [IDX_W-1:0] idx);
        return (idx == 2'd0) ? GRANT_1 :
               (idx == 2'd1) ? GRANT_2 :
               (idx == 2'd2) ? GRANT_3 : GRANT_4;
    endfunction

endpackage

// File: rtl/mem_share_arbiter_rr_pick.sv
// rr_pick: rotating priority encoder, first eligible requester at or above rr_ptr, wrapping 3 -> 0
module rr_pick
    import mem_share_pkg::*;
(
    input  logic [N_REQ-1:0] req_eligible,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_valid
);

    logic [2*N_REQ-1:0] doubled;
    logic [N_REQ-1:0]   rotated;
    logic [IDX_W-1:0]   offset;

    assign doubled = {req_eligible, req_eligible};
    assign rotated = N_REQ'(doubled >> rr_ptr);

    // lowest set bit of the rotated view is the nearest eligible requester above the pointer
    always_comb begin
        offset = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (rotated[i]) offset = IDX_W'(i);
    end

    assign win_idx   = rr_ptr + offset;
    assign win_valid = |req_eligible;

endmodule

// File: rtl/mem_share_arbiter.sv
// mem_share_arbiter: round-robin single-owner arbiter for the shared 12x1024 common word memory.
// Hold-time preemption with requester lockout is built only when MEM_SHARE_ARBITER_TIMEOUT_EN is defined.
module mem_share_arbiter
    import mem_share_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int MAX_HOLD   = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout_err
);

    if (GAP_CYCLES < 1 || GAP_CYCLES > 15 || MAX_HOLD < 2) begin : g_bad_params
        $error("mem_share_arbiter: GAP_CYCLES must be 1..15 and MAX_HOLD at least 2");
    end

    state_t           state, state_n;
    logic [N_REQ-1:0] grant_n, eligible;
    logic [IDX_W-1:0] idx_n, rr_ptr, ptr_n, win_idx;
    logic [3:0]       gap_cnt, gap_n;
    logic             win_valid, owner_release, timeout_hit, tmo_n;

`ifdef MEM_SHARE_ARBITER_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);

    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic [N_REQ-1:0]  lockout, lockout_n;

    assign eligible    = req & ~lockout;
    assign timeout_hit = hold_cnt == HOLD_W'(MAX_HOLD - 1);

    // hold-time counter and the mask keeping a preempted requester out until it drops req
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
            lockout  <= '0;
        end else begin
            hold_cnt <= hold_n;
            lockout  <= lockout_n;
        end
    end
`else
    assign eligible    = req;
    assign timeout_hit = 1'b0;
`endif

    rr_pick u_pick (
        .req_eligible(eligible),
        .rr_ptr      (rr_ptr),
        .win_idx     (win_idx),
        .win_valid   (win_valid)
    );

    // done and req-drop from the owner in the same cycle are a single release
    assign owner_release = !req[grant_idx] || done[grant_idx];

    // next state: arbitrate in IDLE, release or preempt in OWNED, count idle cycles in GAP
    always_comb begin
        state_n = state;
        grant_n = grant;
        idx_n   = grant_idx;
        ptr_n   = rr_ptr;
        gap_n   = gap_cnt;
        tmo_n   = 1'b0;
`ifdef MEM_SHARE_ARBITER_TIMEOUT_EN
        hold_n  = (state == OWNED) ? hold_cnt + 1'b1 : hold_cnt;
`endif
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_n = OWNED;
                    grant_n = idx_to_grant(win_idx);
                    idx_n   = win_idx;
                    ptr_n   = win_idx + 1'b1;
`ifdef MEM_SHARE_ARBITER_TIMEOUT_EN
                    hold_n  = '0;
`endif
                end
            end
            OWNED: begin
                if (owner_release || timeout_hit) begin
                    state_n = (GAP_CYCLES > 1) ? GAP : IDLE;
                    grant_n = '0;
                    gap_n   = 4'(GAP_CYCLES - 1);
                    tmo_n   = !owner_release;
                end
            end
            GAP: begin
                gap_n   = gap_cnt - 4'd1;
                state_n = (gap_cnt <= 4'd1) ? IDLE : GAP;
            end
            default: state_n = IDLE;
        endcase
`ifdef MEM_SHARE_ARBITER_TIMEOUT_EN
        lockout_n = (lockout & req) | (tmo_n ? grant : '0);
`endif
    end

    // state and registered outputs; reset drops any grant on the same edge with no drain
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout_err <= 1'b0;
            rr_ptr      <= '0;
            gap_cnt     <= '0;
        end else begin
            state       <= state_n;
            grant       <= grant_n;
            grant_idx   <= idx_n;
            grant_valid <= |grant_n;
            timeout_err <= tmo_n;
            rr_ptr      <= ptr_n;
            gap_cnt     <= gap_n;
        end
    end

endmodule

// File: tb/tb_mem_share_arbiter.sv
// tb_mem_share_arbiter: directed scenarios plus random traffic against a cycle-level reference model
module tb_mem_share_arbiter;

    localparam int GAP  = 2;
    localparam int HOLD = 16;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = '0;
    logic [3:0] done  = '0;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid, timeout_err;

    int n_pass = 0;
    int n_chk  = 0;

    int         cyc      = 0;
    int         m_owner  = -1;
    int         m_last   = 0;
    int         m_ptr    = 0;
    int         m_arb_at = 0;
    int         m_gcyc   = 0;
    logic [3:0] m_lock   = '0;
    logic       m_tmo    = 1'b0;
    logic [3:0] prev_grant = '0;

    mem_share_arbiter #(.GAP_CYCLES(GAP), .MAX_HOLD(HOLD)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: who owns the memory, when arbitration is next allowed, and the search pointer
    task automatic model_step();
        logic [3:0] elig;
        cyc++;
        m_tmo = 1'b0;
        if (reset) begin
            m_owner  = -1;
            m_last   = 0;
            m_ptr    = 0;
            m_arb_at = cyc + 1;
            m_lock   = '0;
        end else begin
            elig   = req & ~m_lock;
            m_lock = m_lock & req;
            if (m_owner >= 0) begin
                if (!req[m_owner] || done[m_owner]) begin
                    m_owner  = -1;
                    m_arb_at = cyc + GAP;
                end
`ifdef MEM_SHARE_ARBITER_TIMEOUT_EN
                else if (cyc - m_gcyc == HOLD) begin
                    m_lock[m_owner] = 1'b1;
                    m_tmo    = 1'b1;
                    m_owner  = -1;
                    m_arb_at = cyc + GAP;
                end
`endif
            end else if (cyc >= m_arb_at) begin
                for (int k = 0; k < 4; k++)
                    if (m_owner < 0 && elig[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
                if (m_owner >= 0) begin
                    m_last = m_owner;
                    m_ptr  = (m_owner + 1) % 4;
                    m_gcyc = cyc;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [3:0] eg;
        eg = (m_owner >= 0) ? 4'b0001 << m_owner : 4'b0000;
        chk("grant", 32'(grant), 32'(eg));
        chk("grant_idx", 32'(grant_idx), 32'(m_last));
        chk("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
        chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
        chk("one_hot", 32'($countones(grant) <= 1), 32'(1));
        chk("no_direct_switch", 32'(prev_grant != 0 && grant != 0 && prev_grant != grant), 32'(0));
        prev_grant = grant;
    endtask

    task automatic step(input logic r, input logic [3:0] q, input logic [3:0] d);
        reset = r;
        req   = q;
        done  = d;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    initial begin
        int held;
        int tmos;
        logic [3:0] q;
        logic [3:0] d;
        // reset with all requests pending, then first grant one cycle after release
        repeat (3) begin
            step(1'b1, 4'hF, 4'h0);
            chk("rst_grant", 32'(grant), 32'(0));
        end
        step(1'b0, 4'hF, 4'h0);
        chk("first_grant", 32'(grant), 32'(4'b0001));
        // rotation with done five cycles after each grant
        for (int k = 0; k < 4; k++) begin
            repeat (4) step(1'b0, 4'hF, 4'h0);
            step(1'b0, 4'hF, 4'b0001 << k);
            chk("rot_gap0", 32'(grant), 32'(0));
            step(1'b0, 4'hF, 4'h0);
            chk("rot_gap1", 32'(grant), 32'(0));
            step(1'b0, 4'hF, 4'h0);
            chk("rot_grant", 32'(grant), 32'(4'b0001 << ((k + 1) % 4)));
        end
        // skip to owner 2, then wrap from pointer 3 back to requester 0
        repeat (3) step(1'b0, 4'b0100, 4'h0);
        chk("skip_grant", 32'(grant), 32'(4'b0100));
        step(1'b0, 4'b0100, 4'h0);
        repeat (3) step(1'b0, 4'b0011, 4'h0);
        chk("wrap_grant", 32'(grant), 32'(4'b0001));
        step(1'b0, 4'b0011, 4'b0001);
        repeat (2) step(1'b0, 4'b0011, 4'h0);
        chk("wrap_next", 32'(grant), 32'(4'b0010));
        // done from non-owners is ignored
        step(1'b0, 4'b0011, 4'b0101);
        chk("foreign_done", 32'(grant), 32'(4'b0010));
        // req drop and done together form one release and one gap
        step(1'b0, 4'b0001, 4'b0010);
        chk("dual_rel0", 32'(grant), 32'(0));
        step(1'b0, 4'b0001, 4'h0);
        chk("dual_rel1", 32'(grant), 32'(0));
        step(1'b0, 4'b0001, 4'h0);
        chk("single_gap", 32'(grant), 32'(4'b0001));
        // reset while requester 3 owns the memory
        repeat (3) step(1'b0, 4'b1000, 4'h0);
        chk("owner3", 32'(grant), 32'(4'b1000));
        step(1'b0, 4'b1000, 4'h0);
        step(1'b1, 4'b1000, 4'h0);
        chk("mid_reset", 32'(grant), 32'(0));
        step(1'b0, 4'hF, 4'h0);
        chk("post_reset_ptr", 32'(grant), 32'(4'b0001));
        // long hold by requester 1 with no release
        step(1'b1, 4'h0, 4'h0);
        step(1'b0, 4'b0010, 4'h0);
        held = (grant == 4'b0010) ? 1 : 0;
        tmos = 0;
        repeat (120) begin
            step(1'b0, 4'b0010, 4'h0);
            if (grant == 4'b0010) held++;
            if (timeout_err) tmos++;
        end
`ifdef MEM_SHARE_ARBITER_TIMEOUT_EN
        chk("hold_cycles", 32'(held), 32'(HOLD));
        chk("tmo_pulses", 32'(tmos), 32'(1));
`else
        chk("hold_cycles", 32'(held), 32'(121));
        chk("tmo_pulses", 32'(tmos), 32'(0));
`endif
        step(1'b0, 4'b0000, 4'h0);
        step(1'b0, 4'b0010, 4'h0);
`ifdef MEM_SHARE_ARBITER_TIMEOUT_EN
        chk("relock_grant", 32'(grant), 32'(4'b0010));
`else
        chk("relock_grant", 32'(grant), 32'(0));
`endif
        // random traffic with occasional resets
        step(1'b1, 4'h0, 4'h0);
        q = 4'($urandom);
        for (int i = 0; i < 2500; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 31) == 0) q[b] = ~q[b];
                d[b] = ($urandom_range(0, 19) == 0);
            end
            step($urandom_range(0, 299) == 0, q, d);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
